// File: rtl/bram_burst_reader.sv
`default_nettype none
// ============================================================================
// bram_burst_reader - BRAM (base,len) burst read master, 2-entry FIFO stream out
// Revision: 1.0
// ============================================================================
module bram_burst_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] cmd_base_i,
    input  logic [ADDRESS_WIDTH:0]   cmd_len_i,
    output logic [ADDRESS_WIDTH-1:0] raddr_o,
    output logic                     ren_o,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic                     out_last_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
    logic                     inflight_q;
    logic                     last_tag_q, last_tag_d;
    logic                     zero_done_q, zero_done_d;

    logic [DATA_WIDTH-1:0]    fifo_data_q [2];
    logic                     fifo_last_q [2];
    logic                     rd_ptr_q, wr_ptr_q;
    logic [1:0]               count_q;

    logic                     push, pop, issue;
    logic [2:0]               occ;

    assign push        = inflight_q;
    assign out_valid_o = (count_q != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = fifo_data_q[rd_ptr_q];
    assign out_last_o  = out_valid_o & fifo_last_q[rd_ptr_q];

    // Reads in flight count against FIFO space so a stalled consumer can never overflow it.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue = (state_q == S_READ) && ((occ - {2'b00, pop}) < 3'd2);

    assign ren_o   = issue;
    assign raddr_o = issue ? addr_q : raddr_q;
    assign raddr_d = raddr_o;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        last_tag_d  = 1'b0;
        zero_done_d = 1'b0;
        cmd_ready_o = 1'b0;
        done_o      = zero_done_q;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        addr_d      = cmd_base_i;
                        remaining_d = cmd_len_i;
                        state_d     = S_READ;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    last_tag_d  = (remaining_q == {{ADDRESS_WIDTH{1'b0}}, 1'b1});
                    if (remaining_q == {{ADDRESS_WIDTH{1'b0}}, 1'b1}) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            raddr_q     <= '0;
            inflight_q  <= 1'b0;
            last_tag_q  <= 1'b0;
            zero_done_q <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            raddr_q     <= raddr_d;
            inflight_q  <= issue;
            last_tag_q  <= last_tag_d;
            zero_done_q <= zero_done_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rdata_i;
            fifo_last_q[wr_ptr_q] <= last_tag_q;
        end
    end

`ifndef SYNTHESIS
    a_fifo_no_overflow: assert property (@(posedge clock_i) disable iff (!reset_n_i)
        !(push && !pop && (count_q == 2'd2)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_burst_reader.sv
`default_nettype none
// Randomized self-checking bench: BRAM model + address-order reference for bram_burst_reader.
module tb_bram_burst_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_base;
    logic [11:0] cmd_len;
    logic [10:0] raddr;
    logic        ren;
    logic [15:0] rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        done;

    bram_burst_reader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11)) dut (
        .clock_i     (clk),
        .reset_n_i   (reset_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_base_i  (cmd_base),
        .cmd_len_i   (cmd_len),
        .raddr_o     (raddr),
        .ren_o       (ren),
        .rdata_i     (rdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:2047];
    always @(posedge clk) if (ren) rdata <= mem[raddr];

    int n_tests = 0;
    int n_fail  = 0;

    // Observation record, sampled on the falling edge.
    int          cyc = 0;
    int          iss, accd, first_valid, stall_viol, ren_viol;
    logic [15:0] obs_data [$];
    bit          obs_last [$];
    logic [10:0] obs_raddr [$];
    int          hs_cyc [$], done_cyc [$], acc_cyc [$], ren_cyc [$];
    bit          prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            if (ren) begin
                if ((iss - accd - ((out_valid && out_ready) ? 1 : 0)) >= 2) ren_viol++;
                obs_raddr.push_back(raddr);
                ren_cyc.push_back(cyc);
                iss++;
            end
            if (out_valid && out_ready) begin
                obs_data.push_back(out_data);
                obs_last.push_back(out_last);
                hs_cyc.push_back(cyc);
                accd++;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) done_cyc.push_back(cyc);
            if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    end

    task automatic clear_obs();
        iss = 0; accd = 0; first_valid = -1; stall_viol = 0; ren_viol = 0;
        obs_data.delete(); obs_last.delete(); obs_raddr.delete();
        hs_cyc.delete(); done_cyc.delete(); acc_cyc.delete(); ren_cyc.delete();
    endtask

    task automatic send_cmd(input logic [10:0] b, input logic [11:0] l);
        int n0;
        n0 = acc_cyc.size();
        cmd_base  = b;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            if (acc_cyc.size() > n0) break;
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int bound, input bit rnd);
        for (int k = 0; k < bound; k++) begin
            if (done_cyc.size() >= n) break;
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Counts beats whose data/last differ from the address-order reference.
    function automatic int burst_errs(input int b, input int len, input int from);
        int e = 0;
        for (int i = 0; i < len; i++) begin
            if (from + i >= obs_data.size()) e++;
            else if (obs_data[from + i] !== mem[(b + i) % 2048] ||
                     obs_last[from + i] !== (i == len - 1)) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_last, ren, done, raddr} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b l=%b ren=%b done=%b raddr=%h want all 0",
                     out_valid, out_last, ren, done, raddr);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int e;
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
        clear_obs();
        out_ready = 1'b1;
        send_cmd(11'h010, 12'd4);
        wait_done(1, 200, 1'b0);
        n_tests++;
        if (obs_data.size() !== 4) begin
            n_fail++;
            $display("FAIL basic_beats got %0d want 4", obs_data.size());
        end
        if (obs_data.size() == 4 && acc_cyc.size() == 1 && done_cyc.size() >= 1) begin
            e = 0;
            for (int i = 0; i < 4; i++)
                if (obs_data[i] !== 16'h10 + 16'(i) || obs_last[i] !== (i == 3) ||
                    hs_cyc[i] !== hs_cyc[0] + i) e++;
            n_tests++;
            if (e !== 0) begin
                n_fail++;
                $display("FAIL basic_data got %0d bad beats want 0", e);
            end
            n_tests++;
            if (first_valid !== acc_cyc[0] + 3) begin
                n_fail++;
                $display("FAIL basic_latency got cycle %0d want %0d", first_valid, acc_cyc[0] + 3);
            end
            n_tests++;
            if (done_cyc[0] !== hs_cyc[3] + 1) begin
                n_fail++;
                $display("FAIL basic_done_time got %0d want %0d", done_cyc[0], hs_cyc[3] + 1);
            end
        end
        n_tests++;
        if (done_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL basic_done_count got %0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_wrap();
        int e = 0;
        clear_obs();
        out_ready = 1'b1;
        send_cmd(11'h7FE, 12'd4);
        wait_done(1, 200, 1'b0);
        for (int i = 0; i < 4; i++)
            if (i >= obs_raddr.size() || obs_raddr[i] !== 11'((12'h7FE + i) % 2048)) e++;
        n_tests++;
        if (e !== 0 || obs_raddr.size() !== 4) begin
            n_fail++;
            $display("FAIL wrap_raddr got %0d bad of %0d want 0 of 4", e, obs_raddr.size());
        end
        n_tests++;
        if (burst_errs(11'h7FE, 4, 0) !== 0) begin
            n_fail++;
            $display("FAIL wrap_data got %0d bad beats want 0", burst_errs(11'h7FE, 4, 0));
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] b;
        b = 11'($urandom);
        clear_obs();
        out_ready = 1'b0;
        send_cmd(b, 12'd8);
        wait_done(1, 500, 1'b1);
        n_tests++;
        if (obs_data.size() !== 8 || burst_errs(b, 8, 0) !== 0) begin
            n_fail++;
            $display("FAIL bp_data got %0d beats %0d bad want 8 beats 0 bad",
                     obs_data.size(), burst_errs(b, 8, 0));
        end
        n_tests++;
        if (stall_viol !== 0) begin
            n_fail++;
            $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol);
        end
        n_tests++;
        if (ren_viol !== 0) begin
            n_fail++;
            $display("FAIL bp_ren_full got %0d reads into full FIFO want 0", ren_viol);
        end
        n_tests++;
        if (done_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL bp_done_count got %0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_zero_len();
        clear_obs();
        out_ready = 1'b1;
        send_cmd(11'h055, 12'd0);
        wait_done(1, 50, 1'b0);
        n_tests++;
        if (ren_cyc.size() !== 0 || first_valid !== -1) begin
            n_fail++;
            $display("FAIL zero_activity got ren=%0d valid_cycle=%0d want 0 and -1",
                     ren_cyc.size(), first_valid);
        end
        n_tests++;
        if (done_cyc.size() !== 1 || acc_cyc.size() !== 1 ||
            (done_cyc.size() == 1 && acc_cyc.size() == 1 && done_cyc[0] !== acc_cyc[0] + 1)) begin
            n_fail++;
            $display("FAIL zero_done got %0d pulses want 1 pulse 1 cycle after accept", done_cyc.size());
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_cmd_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_mid_reset();
        clear_obs();
        out_ready = 1'b1;
        send_cmd(11'h200, 12'd8);
        for (int k = 0; k < 100 && obs_data.size() < 3; k++) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_last, ren, done, raddr} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_outputs got v=%b l=%b ren=%b done=%b raddr=%h want all 0",
                     out_valid, out_last, ren, done, raddr);
        end
        reset_n = 1'b1;
        clear_obs();
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (done_cyc.size() !== 0 || first_valid !== -1) begin
            n_fail++;
            $display("FAIL rst_abort got %0d done %0d valid_cycle want 0 and -1",
                     done_cyc.size(), first_valid);
        end
        clear_obs();
        send_cmd(11'h100, 12'd2);
        wait_done(1, 100, 1'b0);
        n_tests++;
        if (obs_data.size() !== 2 || burst_errs(11'h100, 2, 0) !== 0) begin
            n_fail++;
            $display("FAIL rst_newcmd got %0d beats %0d bad want 2 beats 0 bad",
                     obs_data.size(), burst_errs(11'h100, 2, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] b1, b2;
        b1 = 11'($urandom);
        b2 = 11'($urandom);
        clear_obs();
        out_ready = 1'b1;
        send_cmd(b1, 12'd3);
        send_cmd(b2, 12'd1);
        wait_done(2, 200, 1'b0);
        n_tests++;
        if (obs_data.size() !== 4 || burst_errs(b1, 3, 0) !== 0 || burst_errs(b2, 1, 3) !== 0) begin
            n_fail++;
            $display("FAIL b2b_data got %0d beats want 4 matching", obs_data.size());
        end
        n_tests++;
        if (done_cyc.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_done_count got %0d want 2", done_cyc.size());
        end
        n_tests++;
        if (acc_cyc.size() !== 2 || done_cyc.size() < 1 ||
            (acc_cyc.size() == 2 && done_cyc.size() >= 1 && acc_cyc[1] !== done_cyc[0] + 1)) begin
            n_fail++;
            $display("FAIL b2b_accept got %0d accepts, second not 1 cycle after first done",
                     acc_cyc.size());
        end
    endtask

    task automatic test_random_bursts();
        for (int t = 0; t < 6; t++) begin
            logic [10:0] b;
            int          l;
            b = 11'($urandom);
            l = $urandom_range(1, 24);
            clear_obs();
            send_cmd(b, 12'(l));
            wait_done(1, 1000, 1'b1);
            n_tests++;
            if (obs_data.size() !== l || burst_errs(b, l, 0) !== 0 ||
                stall_viol !== 0 || ren_viol !== 0 || done_cyc.size() !== 1) begin
                n_fail++;
                $display("FAIL rand_burst%0d base=%h len=%0d got %0d beats %0d bad stall=%0d ren=%0d done=%0d",
                         t, b, l, obs_data.size(), burst_errs(b, l, 0), stall_viol, ren_viol,
                         done_cyc.size());
            end
        end
    endtask

    task automatic test_full_memory();
        logic [10:0] b;
        b = 11'($urandom);
        clear_obs();
        out_ready = 1'b1;
        send_cmd(b, 12'd2048);
        wait_done(1, 3000, 1'b0);
        n_tests++;
        if (obs_data.size() !== 2048 || burst_errs(b, 2048, 0) !== 0 || done_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL full_mem got %0d beats %0d bad %0d done want 2048 0 1",
                     obs_data.size(), burst_errs(b, 2048, 0), done_cyc.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        clear_obs();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_mid_reset();
        test_back_to_back();
        test_random_bursts();
        test_full_memory();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
